filter_div_43s_18u: RTL
=======================

# filter_div_43s_18u

Sequential radix-2 divider for the DigitalAudio filter datapath. It is the inverse of the filter's unsigned-18 × signed-25 coefficient multiply. It takes a 43-bit signed accumulator value and an 18-bit unsigned divisor (gain or normalisation word), and returns a 25-bit signed quotient plus remainder. Control uses the HLS block-level handshake (start/done/idle/ready), so the block drops into the generated filter core next to its multipliers.

## Interface
Parameters:
- DIVIDEND_WIDTH, 43, signed dividend width
- DIVISOR_WIDTH, 18, unsigned divisor width
- QUOTIENT_WIDTH, 25, signed quotient width

Ports:
- ap_clk  in  1  single clock, all logic on rising edge
- ap_rst  in  1  reset, asynchronous and active-high
- ap_start  in  1  request; sampled only in IDLE
- ap_done  out  1  one-cycle pulse, results valid
- ap_idle  out  1  high in IDLE only
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- din0  in  DIVIDEND_WIDTH  signed dividend
- din1  in  DIVISOR_WIDTH  unsigned divisor
- quot  out  QUOTIENT_WIDTH  signed quotient, truncated toward zero, saturated
- rem  out  DIVISOR_WIDTH+1  signed remainder; sign follows the dividend
- ovf  out  1  quotient saturated
- div_zero  out  1  divisor was zero

## Operation
- FSM states: IDLE → CALC → FIX → DONE → IDLE.
- IDLE:
  - ap_idle=1.
  - When ap_start=1, capture din0/din1, the dividend sign, |din0| as a 43-bit unsigned value, and din1.
  - Clear the partial remainder and step counter, then go to CALC.
  - din0/din1 are not sampled again until the next IDLE.
- CALC runs exactly 43 cycles of restoring division, MSB first:
  - Shift {R, Q} left by 1.
  - If R ≥ divisor, subtract the divisor and set Q[0]=1.
  - R is DIVISOR_WIDTH+1 bits unsigned.
- FIX runs 1 cycle:
  - Apply signs: quotient negated if the dividend is negative; remainder negated if the dividend is negative.
  - Saturation: if the signed quotient > 2^24−1, output 16777215 with ovf=1. If < −2^24, output −16777216 with ovf=1.
  - The remainder is always the true truncating remainder.
  - Divide by zero: quot = 16777215 when dividend ≥ 0, otherwise −16777216; rem=0, div_zero=1, ovf=0.
  - A zero divisor still traverses CALC, so latency stays fixed.
- DONE runs 1 cycle: ap_done=1, ap_ready=1, then return to IDLE.
- quot/rem/ovf/div_zero are updated only on entry to DONE. They hold until the next DONE.
- ap_start outside IDLE is ignored. No queueing.
- Invariant when ovf=0 and div_zero=0: quot×din1 + rem == din0 and |rem| < din1.

## Timing
- Reset (async assert, released synchronously by the design's reset bridge):
  - State IDLE, ap_idle=1, ap_done=0, ap_ready=0.
  - quot=0, rem=0, ovf=0, div_zero=0, counter=0.
- Latency: ap_start sampled in IDLE at edge N → ap_done high during cycle N+45. That is 43 CALC + 1 FIX + 1 DONE.
- ap_idle falls in the cycle after the start edge and rises again in the cycle after DONE.
- Throughput: one operation per 46 cycles. With ap_start held high, the next operation starts at the IDLE edge following DONE.
- Reset asserted mid-CALC/FIX/DONE:
  - Immediate abort to reset values; no ap_done pulse.
  - A new start is accepted on the first edge after release.
- Combinational depth per cycle: one 19-bit compare/subtract plus the mux.

## Test plan
- Basic: din0=1000000, din1=3 → quot=333333, rem=1, ovf=0, div_zero=0. ap_done exactly 45 cycles after the start edge, one cycle wide.
- Negative truncation: din0=−7, din1=2 → quot=−3, rem=−1. Also din0=−6, din1=262143 → quot=0, rem=−6.
- Saturation:
  - din0=2^30, din1=1 → quot=16777215, ovf=1, rem=0.
  - din0=−2^42, din1=1 → quot=−16777216, ovf=1.
  - din0=−2^24, din1=1 → quot=−16777216, ovf=0.
- Divide by zero: din0=5, din1=0 → quot=16777215, rem=0, div_zero=1, ovf=0. din0=−5, din1=0 → quot=−16777216, div_zero=1.
- Handshake:
  - ap_start held high: back-to-back results every 46 cycles.
  - din0/din1 changed mid-CALC do not affect the result.
  - Start pulses during CALC are ignored.
- Reset: assert ap_rst at CALC step 20 → all outputs zero and ap_idle=1 immediately. A restart after release completes normally.
- Random: 10^5 random din0/din1, checked against a reference model using the quot×din1+rem invariant.

Source files
------------

// File: rtl/filter_div_43s_18u.sv
// Sequential restoring divider: signed 43-bit dividend by unsigned 18-bit divisor,
// saturated signed 25-bit quotient and dividend-signed remainder, HLS block handshake.
`timescale 1ns/1ps
module filter_div_43s_18u #(
    parameter int DIVIDEND_WIDTH = 43,
    parameter int DIVISOR_WIDTH  = 18,
    parameter int QUOTIENT_WIDTH = 25
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      ap_start,
    output logic                      ap_done,
    output logic                      ap_idle,
    output logic                      ap_ready,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic [QUOTIENT_WIDTH-1:0] quot,
    output logic [DIVISOR_WIDTH:0]    rem,
    output logic                      ovf,
    output logic                      div_zero
);

    localparam int DW = DIVIDEND_WIDTH;
    localparam int RW = DIVISOR_WIDTH + 1;
    localparam int QW = QUOTIENT_WIDTH;
    localparam int CW = 6;
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);
    localparam logic [DW-1:0] POS_LIM   = DW'((64'd1 << (QW - 1)) - 64'd1);
    localparam logic [DW-1:0] NEG_LIM   = DW'(64'd1 << (QW - 1));
    localparam logic [QW-1:0] Q_POS_SAT = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] Q_NEG_SAT = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [DW-1:0] mag_of(input logic [DW-1:0] v);
        if (v[DW-1]) begin
            return ~v + DW'(1);
        end else begin
            return v;
        end
    endfunction

    function automatic logic [QW-1:0] neg_q(input logic [QW-1:0] v);
        return ~v + QW'(1);
    endfunction

    function automatic logic [RW-1:0] neg_r(input logic [RW-1:0] v);
        return ~v + RW'(1);
    endfunction

    state_t          state_r, state_nxt_s;
    logic            rst_meta_r, rst_sync_r;
    logic            sign_r;
    logic [DW-1:0]   q_r;
    logic [RW-1:0]   r_r;
    logic [DIVISOR_WIDTH-1:0] d_r;
    logic [CW-1:0]   cnt_r;
    logic [RW:0]     trial_s, diff_s;
    logic            ge_s;
    logic [QW-1:0]   fix_quot_s;
    logic [RW-1:0]   fix_rem_s;
    logic            fix_ovf_s, fix_dz_s;

    // Reset bridge: assert immediately, release on a clock edge
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= 1'b1;
        end else begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= rst_meta_r;
        end
    end

    // State register
    always_ff @(posedge ap_clk or posedge rst_sync_r) begin
        if (rst_sync_r) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (ap_start) begin
                    state_nxt_s = S_CALC;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_r == LAST_STEP) begin
                    state_nxt_s = S_FIX;
                end else begin
                    state_nxt_s = S_CALC;
                end
            end
            S_FIX:   state_nxt_s = S_DONE;
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        case (state_r)
            S_IDLE:  ap_idle = 1'b1;
            S_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
            end
            default: ap_idle = 1'b0;
        endcase
    end

    // One restoring step; sign bit of the trial difference says "does not fit"
    always_comb begin
        trial_s = {r_r, q_r[DW-1]};
        diff_s  = trial_s - {2'b00, d_r};
        ge_s    = ~diff_s[RW];
    end

    // Sign application, saturation and divide-by-zero override
    always_comb begin
        fix_quot_s = {QW{1'b0}};
        fix_ovf_s  = 1'b0;
        fix_dz_s   = 1'b0;
        fix_rem_s  = sign_r ? neg_r(r_r) : r_r;
        if (d_r == {DIVISOR_WIDTH{1'b0}}) begin
            fix_quot_s = sign_r ? Q_NEG_SAT : Q_POS_SAT;
            fix_rem_s  = {RW{1'b0}};
            fix_dz_s   = 1'b1;
        end else if (!sign_r && (q_r > POS_LIM)) begin
            fix_quot_s = Q_POS_SAT;
            fix_ovf_s  = 1'b1;
        end else if (sign_r && (q_r > NEG_LIM)) begin
            fix_quot_s = Q_NEG_SAT;
            fix_ovf_s  = 1'b1;
        end else begin
            fix_quot_s = sign_r ? neg_q(q_r[QW-1:0]) : q_r[QW-1:0];
        end
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge ap_clk or posedge rst_sync_r) begin
        if (rst_sync_r) begin
            sign_r   <= 1'b0;
            q_r      <= {DW{1'b0}};
            r_r      <= {RW{1'b0}};
            d_r      <= {DIVISOR_WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            quot     <= {QW{1'b0}};
            rem      <= {RW{1'b0}};
            ovf      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (ap_start) begin
                        sign_r <= din0[DW-1];
                        q_r    <= mag_of(din0);
                        d_r    <= din1;
                        r_r    <= {RW{1'b0}};
                        cnt_r  <= {CW{1'b0}};
                    end else begin
                        cnt_r  <= cnt_r;
                    end
                end
                S_CALC: begin
                    r_r   <= ge_s ? diff_s[RW-1:0] : trial_s[RW-1:0];
                    q_r   <= {q_r[DW-2:0], ge_s};
                    cnt_r <= cnt_r + CW'(1);
                end
                S_FIX: begin
                    quot     <= fix_quot_s;
                    rem      <= fix_rem_s;
                    ovf      <= fix_ovf_s;
                    div_zero <= fix_dz_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule
